simon_pattern_buffer: RTL and testbench
=======================================

# simon_pattern_buffer

Parametrised pattern-store datapath for the Simon game: holds the growing colour sequence in an internal circular memory, walks a playback/check cursor across it, and supplies the compare and status flags the Simon controller FSM consumes. It generalises the pattern/LED width and memory depth, and adds two runtime level modes: easy saturates when full; hard slides a window over the oldest entries. It sits between the switch/LED pins and the game controller.

## Interface
- `WIDTH`, 4, number of pattern switches/LEDs (≥2)
- `ADDR_W`, 6, memory address width; `DEPTH` = 2**`ADDR_W` entries
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `level`  in  1  level switch, sampled on `level_ld`
- `pattern`  in  WIDTH  switch pattern being entered
- `level_ld`  in  1  latch `level` into `curr_level`
- `clr`  in  1  empty the store
- `append`  in  1  write `pattern` as newest entry
- `cur_rst`  in  1  move cursor to oldest entry
- `cur_adv`  in  1  advance cursor
- `show_input`  in  1  LED mux: 1 = `pattern`, 0 = entry at cursor
- `curr_level`  out  1  latched level (0 easy, 1 hard)
- `cur_eq_last`  out  1  cursor is on newest entry
- `ptrn_eq_input`  out  1  `pattern` equals entry at cursor
- `is_legal`  out  1  exactly one bit of `pattern` set
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `length`  out  ADDR_W+1  number of valid entries (0..DEPTH)
- `pattern_leds`  out  WIDTH  LED drive

## Operation
- State: `head` (ADDR_W, oldest entry index), `count` (ADDR_W+1), `offset` (ADDR_W, cursor relative to `head`), `level_reg`, memory DEPTH×WIDTH.
- Cursor entry address = (`head` + `offset`) mod DEPTH; write address = (`head` + `count`) mod DEPTH; all pointer arithmetic wraps modulo DEPTH.
- `clr`: `head`, `count`, `offset` ← 0. Overrides `append`, `cur_rst`, `cur_adv` in the same cycle; `level_ld` still acts.
- `append`, count < DEPTH: write memory, `count`+1.
- `append`, full, `level_reg`=0: ignored; memory, `head`, `count` unchanged.
- `append`, full, `level_reg`=1: overwrite entry at `head` (== write address), `head`+1, `count` stays DEPTH.
- `cur_rst`: `offset` ← 0; overrides `cur_adv`.
- `cur_adv`: if `offset` == count−1 (using pre-update `count`) or `count` == 0, `offset` ← 0; else `offset`+1.
- `append` and `cur_adv`/`cur_rst` in one cycle: both act independently, evaluated on pre-update state. A hard-mode overwrite shifts `head`, so the cursor follows the window (offset-relative).
- `level_ld`: `level_reg` ← `level`; independent of all other commands.
- Cursor entry reads 0 when `empty`.
- `ptrn_eq_input` = (`pattern` == cursor entry) and not `empty`.
- `cur_eq_last` = not `empty` and `offset` == count−1.
- `is_legal` = popcount(`pattern`) == 1, for any WIDTH.
- `pattern_leds` = `show_input` ? `pattern` : cursor entry.

## Timing
- Memory write synchronous. Read asynchronous from registered pointers: a written entry is visible the cycle after `append`.
- All flag outputs are combinational from registers and `pattern`; zero-latency compare.
- `rst`, synchronous, highest priority: `head`, `count`, `offset`, `level_reg` ← 0. Memory contents are not cleared; they are unreachable because `count` = 0.
- After reset: `empty`=1, `full`=0, `length`=0, `curr_level`=0, `cur_eq_last`=0, `ptrn_eq_input`=0, `pattern_leds`=`show_input`?`pattern`:0, `is_legal` follows `pattern`.
- Reset asserted mid-game, together with any command: reset wins and the command is discarded.
- No handshake. Each command is a single-cycle level sampled at the edge. Holding `append` high appends once per cycle.

## Test plan
- Reset, then append 0001, 0010, 0100 (WIDTH=4) -> `length`=3. After `cur_rst`, `cur_adv` ×2: LEDs 0001, 0010, 0100, with `cur_eq_last`=1 only on the third. A further `cur_adv` wraps the cursor to 0001.
- Easy mode, ADDR_W=2: append 5 entries -> `full`=1, `length`=4; the fifth is ignored and the cursor walk returns entries 1–4.
- Hard mode (`level`=1, `level_ld`), ADDR_W=2: append A,B,C,D,E -> `head`=1, and the walk from `cur_rst` yields B,C,D,E with `full` held.
- `pattern` sweep 0000..1111 -> `is_legal`=1 only for 0001/0010/0100/1000. With the cursor entry 0100 and `pattern`=0100, `ptrn_eq_input`=1; with `pattern`=0110, it is 0.
- `clr` with `append`+`cur_adv` in the same cycle -> next cycle `empty`=1, `length`=0, `offset`=0. Assert `rst` mid-walk -> all outputs at reset values next cycle.
- `append` and `cur_adv` together at `offset`=count−1 -> cursor wraps to 0 (old count) and `length`+1.

Source files
------------

// File: rtl/simon_pattern_buffer_if.sv
// Signal bundle between the Simon controller / switch pins and the pattern buffer.
// The master drives commands and the switch pattern; the slave returns flags and LED drive.
interface simon_pattern_buffer_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ADDR_W = 6
);
  logic              level;
  logic [WIDTH-1:0]  pattern;
  logic              level_ld;
  logic              clr;
  logic              append;
  logic              cur_rst;
  logic              cur_adv;
  logic              show_input;
  logic              curr_level;
  logic              cur_eq_last;
  logic              ptrn_eq_input;
  logic              is_legal;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   length;
  logic [WIDTH-1:0]  pattern_leds;

  modport master (
    output level, pattern, level_ld, clr, append, cur_rst, cur_adv, show_input,
    input  curr_level, cur_eq_last, ptrn_eq_input, is_legal, empty, full, length, pattern_leds
  );

  modport slave (
    input  level, pattern, level_ld, clr, append, cur_rst, cur_adv, show_input,
    output curr_level, cur_eq_last, ptrn_eq_input, is_legal, empty, full, length, pattern_leds
  );
endinterface

// File: rtl/simon_pattern_buffer.sv
// Circular pattern store for the Simon game: appends colours, walks a playback cursor and
// produces compare/status flags. Easy level saturates when full; hard level slides the window.
module simon_pattern_buffer #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ADDR_W = 6
) (
  input logic                  clk,
  input logic                  rst,
  simon_pattern_buffer_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CountFull = (ADDR_W + 1)'(Depth);
  localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);

  logic [WIDTH-1:0]  mem_q [Depth];
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic              level_q, level_d;
  logic              mem_we;

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] cur_addr;
  logic              is_empty;
  logic              is_full;
  logic              at_last;
  logic [WIDTH-1:0]  cur_entry;

  // When full the low count bits are zero, so the write address lands on head.
  assign wr_addr  = head_q + count_q[ADDR_W-1:0];
  assign cur_addr = head_q + offset_q;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CountFull);
  assign at_last  = !is_empty && ({1'b0, offset_q} == (count_q - CountOne));

  always_comb begin
    head_d   = head_q;
    count_d  = count_q;
    offset_d = offset_q;
    level_d  = bus.level_ld ? bus.level : level_q;
    mem_we   = 1'b0;

    if (bus.clr) begin
      head_d   = '0;
      count_d  = '0;
      offset_d = '0;
    end else begin
      if (bus.append) begin
        if (!is_full) begin
          mem_we  = 1'b1;
          count_d = count_q + CountOne;
        end else if (level_q) begin
          // Hard level: drop the oldest entry; offset is head-relative so the cursor follows.
          mem_we = 1'b1;
          head_d = head_q + PtrOne;
        end
      end

      if (bus.cur_rst) begin
        offset_d = '0;
      end else if (bus.cur_adv) begin
        offset_d = (is_empty || at_last) ? '0 : offset_q + PtrOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      count_q  <= '0;
      offset_q <= '0;
      level_q  <= 1'b0;
    end else begin
      head_q   <= head_d;
      count_q  <= count_d;
      offset_q <= offset_d;
      level_q  <= level_d;
    end
  end

  // Storage is never cleared; count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[wr_addr] <= bus.pattern;
    end
  end

  assign cur_entry = is_empty ? '0 : mem_q[cur_addr];

  assign bus.curr_level    = level_q;
  assign bus.cur_eq_last   = at_last;
  assign bus.ptrn_eq_input = !is_empty && (bus.pattern == cur_entry);
  assign bus.is_legal      = (bus.pattern != '0) &&
                             ((bus.pattern & (bus.pattern - WIDTH'(1))) == '0);
  assign bus.empty         = is_empty;
  assign bus.full          = is_full;
  assign bus.length        = count_q;
  assign bus.pattern_leds  = bus.show_input ? bus.pattern : cur_entry;

endmodule

// File: tb/tb_simon_pattern_buffer.sv
// Scoreboard bench for simon_pattern_buffer (WIDTH=4, ADDR_W=2): a queue-based reference
// model predicts the outputs each cycle; a negedge monitor pops and compares.
module tb_simon_pattern_buffer;

  localparam int unsigned Width = 4;
  localparam int unsigned AddrW = 2;
  localparam int unsigned Depth = 4;

  localparam int unsigned CRst    = 1;
  localparam int unsigned CClr    = 2;
  localparam int unsigned CApp    = 4;
  localparam int unsigned CCurRst = 8;
  localparam int unsigned CAdv    = 16;
  localparam int unsigned CLd     = 32;
  localparam int unsigned CLvl    = 64;

  typedef struct packed {
    logic             lvl;
    logic             last;
    logic             eq;
    logic             legal;
    logic             empty;
    logic             full;
    logic [AddrW:0]   len;
    logic [Width-1:0] leds;
  } obs_t;

  logic clk = 1'b0;
  logic rst;

  simon_pattern_buffer_if #(.WIDTH(Width), .ADDR_W(AddrW)) bus ();

  simon_pattern_buffer #(.WIDTH(Width), .ADDR_W(AddrW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the valid entries oldest-first, and the cursor as an index into them.
  logic [Width-1:0] mq[$];
  int               m_off;
  bit               m_lvl;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  string tag = "reset";

  function automatic obs_t predict(input logic [Width-1:0] p, input bit sh);
    obs_t o;
    logic [Width-1:0] ce;
    int n = 0;
    n = mq.size();
    ce = (n == 0) ? '0 : mq[m_off];
    o.lvl   = m_lvl;
    o.last  = (n != 0) && (m_off == n - 1);
    o.eq    = (n != 0) && (p == ce);
    o.legal = ($countones(p) == 1);
    o.empty = (n == 0);
    o.full  = (n == Depth);
    o.len   = (AddrW + 1)'(n);
    o.leds  = sh ? p : ce;
    return o;
  endfunction

  task automatic model_edge(input int unsigned cmd, input logic [Width-1:0] p);
    int  n = 0;
    bit  old_lvl;
    n = mq.size();
    old_lvl = m_lvl;
    if ((cmd & CRst) != 0) begin
      mq.delete();
      m_off = 0;
      m_lvl = 1'b0;
      return;
    end
    if ((cmd & CLd) != 0) m_lvl = ((cmd & CLvl) != 0);
    if ((cmd & CClr) != 0) begin
      mq.delete();
      m_off = 0;
      return;
    end
    if ((cmd & CCurRst) != 0) m_off = 0;
    else if ((cmd & CAdv) != 0) m_off = (n == 0 || m_off == n - 1) ? 0 : m_off + 1;
    if ((cmd & CApp) != 0) begin
      if (n < Depth) begin
        mq.push_back(p);
      end else if (old_lvl) begin
        void'(mq.pop_front());
        mq.push_back(p);
      end
    end
  endtask

  // Called at posedge+1: drive this cycle's inputs, queue the prediction, then take the edge.
  task automatic cyc(input int unsigned cmd, input logic [Width-1:0] p, input bit sh);
    rst            = ((cmd & CRst) != 0);
    bus.clr        = ((cmd & CClr) != 0);
    bus.append     = ((cmd & CApp) != 0);
    bus.cur_rst    = ((cmd & CCurRst) != 0);
    bus.cur_adv    = ((cmd & CAdv) != 0);
    bus.level_ld   = ((cmd & CLd) != 0);
    bus.level      = ((cmd & CLvl) != 0);
    bus.pattern    = p;
    bus.show_input = sh;
    exp_q.push_back(predict(p, sh));
    @(posedge clk);
    model_edge(cmd, p);
    #1;
  endtask

  always @(negedge clk) begin
    obs_t act;
    obs_t exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act.lvl   = bus.curr_level;
      act.last  = bus.cur_eq_last;
      act.eq    = bus.ptrn_eq_input;
      act.legal = bus.is_legal;
      act.empty = bus.empty;
      act.full  = bus.full;
      act.len   = bus.length;
      act.leds  = bus.pattern_leds;
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s @%0t: got lvl=%b last=%b eq=%b legal=%b empty=%b full=%b len=%0d leds=%b, expected lvl=%b last=%b eq=%b legal=%b empty=%b full=%b len=%0d leds=%b",
                 tag, $time, act.lvl, act.last, act.eq, act.legal, act.empty, act.full, act.len,
                 act.leds, exp.lvl, exp.last, exp.eq, exp.legal, exp.empty, exp.full, exp.len,
                 exp.leds);
      end
    end
  end

  initial begin
    logic [Width-1:0] p;
    int unsigned      cmd;
    mq.delete();
    m_off = 0;
    m_lvl = 1'b0;
    rst = 1'b1;
    bus.clr = 1'b0; bus.append = 1'b0; bus.cur_rst = 1'b0; bus.cur_adv = 1'b0;
    bus.level_ld = 1'b0; bus.level = 1'b0; bus.pattern = '0; bus.show_input = 1'b0;
    @(posedge clk);
    model_edge(CRst, '0);
    #1;

    tag = "after_reset";
    cyc(0, 4'b0000, 1'b0);
    cyc(0, 4'b1010, 1'b1);

    tag = "basic_walk";
    cyc(CApp, 4'b0001, 1'b0);
    cyc(CApp, 4'b0010, 1'b0);
    cyc(CApp, 4'b0100, 1'b0);
    cyc(CCurRst, 4'b0000, 1'b0);
    cyc(CAdv, 4'b0000, 1'b0);
    cyc(CAdv, 4'b0000, 1'b0);
    cyc(CAdv, 4'b0000, 1'b0);
    cyc(0, 4'b0000, 1'b0);

    tag = "compare";
    cyc(CAdv, 4'b0000, 1'b0);
    cyc(CAdv, 4'b0100, 1'b0);
    cyc(0, 4'b0110, 1'b0);
    cyc(0, 4'b0100, 1'b1);

    tag = "legal_sweep";
    for (int i = 0; i < 16; i++) begin
      p = 4'(i);
      cyc(0, p, 1'b1);
    end

    tag = "append_adv_at_last";
    cyc(CApp | CAdv, 4'b1000, 1'b0);
    cyc(0, 4'b0000, 1'b0);

    tag = "easy_full";
    cyc(CApp, 4'b0001, 1'b0);
    cyc(CApp, 4'b0010, 1'b0);
    cyc(CCurRst, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) cyc(CAdv, 4'b0000, 1'b0);

    tag = "clr_override";
    cyc(CClr | CApp | CAdv, 4'b0001, 1'b0);
    cyc(0, 4'b0001, 1'b0);

    tag = "hard_window";
    cyc(CLd | CLvl, 4'b0000, 1'b0);
    cyc(CApp, 4'b0001, 1'b0);
    cyc(CApp, 4'b0010, 1'b0);
    cyc(CApp, 4'b0100, 1'b0);
    cyc(CApp, 4'b1000, 1'b0);
    cyc(CApp, 4'b0011, 1'b0);
    cyc(CCurRst, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) cyc(CAdv, 4'b0000, 1'b0);
    cyc(CApp | CAdv, 4'b1100, 1'b0);
    cyc(0, 4'b0000, 1'b0);

    tag = "rst_mid_walk";
    cyc(CRst | CApp | CAdv | CLd | CLvl, 4'b0001, 1'b0);
    cyc(0, 4'b0101, 1'b0);
    cyc(0, 4'b0101, 1'b1);

    tag = "random";
    for (int i = 0; i < 3000; i++) begin
      cmd = 0;
      if ($urandom_range(0, 299) == 0) cmd |= CRst;
      if ($urandom_range(0, 39) == 0)  cmd |= CClr;
      if ($urandom_range(0, 1) == 0)   cmd |= CApp;
      if ($urandom_range(0, 9) == 0)   cmd |= CCurRst;
      if ($urandom_range(0, 1) == 0)   cmd |= CAdv;
      if ($urandom_range(0, 24) == 0)  cmd |= CLd;
      if ($urandom_range(0, 1) == 0)   cmd |= CLvl;
      if ($urandom_range(0, 3) == 0) p = 4'($urandom_range(0, 15));
      else                            p = 4'(1 << $urandom_range(0, 3));
      cyc(cmd, p, ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
